// File: rtl/ibr_mp.sv
`default_nettype none
// ============================================================================
// Module      : ibr_mp
// Description : Multi-port integer branch resolution unit. Branches resolve in
//               EX0, results register into EX1, and EX1 mispredicts are
//               arbitrated oldest-first into a pending redirect register.
// Revision    : 1.0 - initial release
// ============================================================================
module ibr_mp #(
    parameter int NUM_PORTS = 2,
    parameter int XLEN      = 64,
    parameter int PADDR_W   = 64,
    parameter int ROM_W     = 12,
    parameter int ROBID_W   = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           iss_ex0,
    input  logic [NUM_PORTS*4-1:0]         uop_ex0,
    input  logic [NUM_PORTS*PADDR_W-1:0]   pc_ex0,
    input  logic [NUM_PORTS*ROM_W-1:0]     rom_addr_ex0,
    input  logic [NUM_PORTS-1:0]           from_ucrom_ex0,
    input  logic [NUM_PORTS-1:0]           eom_ex0,
    input  logic [NUM_PORTS*XLEN-1:0]      imm_ex0,
    input  logic [NUM_PORTS*XLEN-1:0]      src1_ex0,
    input  logic [NUM_PORTS*XLEN-1:0]      src2_ex0,
    input  logic [NUM_PORTS*ROBID_W-1:0]   robid_ex0,
    input  logic                           flush_ack,
    output logic [NUM_PORTS-1:0]           resvld_ex1,
    output logic [NUM_PORTS*XLEN-1:0]      result_ex1,
    output logic                           mispred_valid,
    output logic [PADDR_W-1:0]             mispred_target,
    output logic [ROBID_W-1:0]             mispred_robid,
    output logic                           mispred_ucbr,
    output logic [15:0]                    mispred_cnt
);

    localparam logic [3:0]  c_UOP_EQ   = 4'd0;
    localparam logic [3:0]  c_UOP_NE   = 4'd1;
    localparam logic [3:0]  c_UOP_LT   = 4'd2;
    localparam logic [3:0]  c_UOP_GE   = 4'd3;
    localparam logic [3:0]  c_UOP_LTU  = 4'd4;
    localparam logic [3:0]  c_UOP_GEU  = 4'd5;
    localparam logic [3:0]  c_UOP_JAL  = 4'd6;
    localparam logic [3:0]  c_UOP_JALR = 4'd7;
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // a is older than b; the MSB is a wrap bit that flips each pass of the ROB
    function automatic logic f_older(input logic [ROBID_W-1:0] a,
                                     input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1]) begin
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
        end else begin
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
        end
    endfunction

    logic [NUM_PORTS-1:0] w_valid_br;
    logic [NUM_PORTS-1:0] w_mp;
    logic [NUM_PORTS-1:0] w_ucbr;
    logic [PADDR_W-1:0]   w_nxt      [NUM_PORTS];
    logic [PADDR_W-1:0]   w_true_tgt [NUM_PORTS];

    // ------------------------------------------------------------------ EX0
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ex0
            logic [3:0]         w_uop;
            logic [PADDR_W-1:0] w_pc;
            logic [ROM_W-1:0]   w_rom;
            logic [ROM_W-1:0]   w_rom_inc;
            logic [XLEN-1:0]    w_imm;
            logic [XLEN-1:0]    w_src1;
            logic [XLEN-1:0]    w_src2;
            logic [XLEN-1:0]    w_jalr_sum;
            logic [PADDR_W-1:0] w_tkn_tgt;
            logic               w_eq;
            logic               w_lt;
            logic               w_ltu;
            logic               w_tkn;

            assign w_uop  = uop_ex0[p*4 +: 4];
            assign w_pc   = pc_ex0[p*PADDR_W +: PADDR_W];
            assign w_rom  = rom_addr_ex0[p*ROM_W +: ROM_W];
            assign w_imm  = imm_ex0[p*XLEN +: XLEN];
            assign w_src1 = src1_ex0[p*XLEN +: XLEN];
            assign w_src2 = src2_ex0[p*XLEN +: XLEN];

            assign w_eq  = (w_src1 == w_src2);
            assign w_lt  = ($signed(w_src1) < $signed(w_src2));
            assign w_ltu = (w_src1 < w_src2);

            always_comb begin
                w_tkn = 1'b0;
                case (w_uop)
                    c_UOP_EQ:   w_tkn = w_eq;
                    c_UOP_NE:   w_tkn = ~w_eq;
                    c_UOP_LT:   w_tkn = w_lt;
                    c_UOP_GE:   w_tkn = ~w_lt;
                    c_UOP_LTU:  w_tkn = w_ltu;
                    c_UOP_GEU:  w_tkn = ~w_ltu;
                    c_UOP_JAL:  w_tkn = 1'b1;
                    c_UOP_JALR: w_tkn = 1'b1;
                    default:    w_tkn = 1'b0;
                endcase
            end

            // Ucode branches mid-macro fall through to the next ROM slot
            assign w_ucbr[p]   = from_ucrom_ex0[p] & ~eom_ex0[p];
            assign w_rom_inc   = w_rom + ROM_W'(1);
            assign w_nxt[p]    = w_ucbr[p] ? PADDR_W'(w_rom_inc) : (w_pc + PADDR_W'(4));

            assign w_jalr_sum  = w_src1 + w_imm;
            assign w_tkn_tgt   = (w_uop == c_UOP_JALR) ?
                                 (PADDR_W'(w_jalr_sum) & ~PADDR_W'(1)) :
                                 (w_pc + PADDR_W'($signed(w_imm)));

            assign w_true_tgt[p] = w_tkn ? w_tkn_tgt : w_nxt[p];
            assign w_valid_br[p] = iss_ex0[p] & ~w_uop[3];
            assign w_mp[p]       = w_valid_br[p] & (w_true_tgt[p] != w_nxt[p]);
        end
    endgenerate

    // ------------------------------------------------------------------ EX1
    logic [NUM_PORTS-1:0] r_resvld;
    logic [NUM_PORTS-1:0] r_mp;
    logic [NUM_PORTS-1:0] r_ucbr;
    logic [XLEN-1:0]      r_result [NUM_PORTS];
    logic [PADDR_W-1:0]   r_tgt    [NUM_PORTS];
    logic [ROBID_W-1:0]   r_robid  [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resvld <= '0;
            r_mp     <= '0;
            r_ucbr   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_result[p] <= '0;
                r_tgt[p]    <= '0;
                r_robid[p]  <= '0;
            end
        end else begin
            r_resvld <= w_valid_br;
            r_mp     <= w_mp;
            r_ucbr   <= w_ucbr;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_result[p] <= XLEN'(w_nxt[p]);
                r_tgt[p]    <= w_true_tgt[p];
                r_robid[p]  <= robid_ex0[p*ROBID_W +: ROBID_W];
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
            assign result_ex1[p*XLEN +: XLEN] = r_result[p];
        end
    endgenerate

    assign resvld_ex1 = r_resvld;

    // ---------------------------------------------------- oldest-first pick
    logic               w_cand_vld;
    logic [PADDR_W-1:0] w_cand_tgt;
    logic [ROBID_W-1:0] w_cand_robid;
    logic               w_cand_ucbr;

    always_comb begin
        w_cand_vld   = 1'b0;
        w_cand_tgt   = '0;
        w_cand_robid = '0;
        w_cand_ucbr  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_mp[p] && (!w_cand_vld || f_older(r_robid[p], w_cand_robid))) begin
                w_cand_vld   = 1'b1;
                w_cand_tgt   = r_tgt[p];
                w_cand_robid = r_robid[p];
                w_cand_ucbr  = r_ucbr[p];
            end
        end
    end

    // ------------------------------------------------------ pending redirect
    state_t             r_state;
    logic               r_valid;
    logic [PADDR_W-1:0] r_pend_tgt;
    logic [ROBID_W-1:0] r_pend_robid;
    logic               r_pend_ucbr;
    logic [15:0]        r_cnt;
    logic               w_cand_older;
    logic [15:0]        w_cnt_inc;

    assign w_cand_older = w_cand_vld & f_older(w_cand_robid, r_pend_robid);
    assign w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + 16'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_pend_tgt   <= '0;
            r_pend_robid <= '0;
            r_pend_ucbr  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand_vld) begin
                        r_state      <= S_PEND;
                        r_valid      <= 1'b1;
                        r_pend_tgt   <= w_cand_tgt;
                        r_pend_robid <= w_cand_robid;
                        r_pend_ucbr  <= w_cand_ucbr;
                        r_cnt        <= w_cnt_inc;
                    end
                end
                S_PEND: begin
                    // An older mispredict wins even over a same-cycle ack
                    if (w_cand_older) begin
                        r_pend_tgt   <= w_cand_tgt;
                        r_pend_robid <= w_cand_robid;
                        r_pend_ucbr  <= w_cand_ucbr;
                        r_cnt        <= w_cnt_inc;
                    end else if (flush_ack) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mispred_valid  = r_valid;
    assign mispred_target = r_pend_tgt;
    assign mispred_robid  = r_pend_robid;
    assign mispred_ucbr   = r_pend_ucbr;
    assign mispred_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ibr_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibr_mp
// Description : Directed and randomized bench for ibr_mp against a reference
//               model built from the branch rules and modular ROB-age ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibr_mp;

    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     iss_ex0;
    logic [NP*4-1:0]   uop_ex0;
    logic [NP*64-1:0]  pc_ex0;
    logic [NP*12-1:0]  rom_addr_ex0;
    logic [NP-1:0]     from_ucrom_ex0;
    logic [NP-1:0]     eom_ex0;
    logic [NP*64-1:0]  imm_ex0;
    logic [NP*64-1:0]  src1_ex0;
    logic [NP*64-1:0]  src2_ex0;
    logic [NP*6-1:0]   robid_ex0;
    logic              flush_ack;
    logic [NP-1:0]     resvld_ex1;
    logic [NP*64-1:0]  result_ex1;
    logic              mispred_valid;
    logic [63:0]       mispred_target;
    logic [5:0]        mispred_robid;
    logic              mispred_ucbr;
    logic [15:0]       mispred_cnt;

    ibr_mp dut (
        .clk            (clk),
        .reset          (reset),
        .iss_ex0        (iss_ex0),
        .uop_ex0        (uop_ex0),
        .pc_ex0         (pc_ex0),
        .rom_addr_ex0   (rom_addr_ex0),
        .from_ucrom_ex0 (from_ucrom_ex0),
        .eom_ex0        (eom_ex0),
        .imm_ex0        (imm_ex0),
        .src1_ex0       (src1_ex0),
        .src2_ex0       (src2_ex0),
        .robid_ex0      (robid_ex0),
        .flush_ack      (flush_ack),
        .resvld_ex1     (resvld_ex1),
        .result_ex1     (result_ex1),
        .mispred_valid  (mispred_valid),
        .mispred_target (mispred_target),
        .mispred_robid  (mispred_robid),
        .mispred_ucbr   (mispred_ucbr),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    logic        t_iss [NP];
    logic [3:0]  t_uop [NP];
    logic [63:0] t_pc  [NP];
    logic [63:0] t_imm [NP];
    logic [63:0] t_s1  [NP];
    logic [63:0] t_s2  [NP];
    logic [11:0] t_rom [NP];
    logic        t_ucr [NP];
    logic        t_eom [NP];
    logic [5:0]  t_rid [NP];

    always_comb begin
        iss_ex0 = '0; uop_ex0 = '0; pc_ex0 = '0; rom_addr_ex0 = '0;
        from_ucrom_ex0 = '0; eom_ex0 = '0; imm_ex0 = '0;
        src1_ex0 = '0; src2_ex0 = '0; robid_ex0 = '0;
        for (int p = 0; p < NP; p++) begin
            iss_ex0[p]            = t_iss[p];
            uop_ex0[p*4 +: 4]     = t_uop[p];
            pc_ex0[p*64 +: 64]    = t_pc[p];
            rom_addr_ex0[p*12 +: 12] = t_rom[p];
            from_ucrom_ex0[p]     = t_ucr[p];
            eom_ex0[p]            = t_eom[p];
            imm_ex0[p*64 +: 64]   = t_imm[p];
            src1_ex0[p*64 +: 64]  = t_s1[p];
            src2_ex0[p*64 +: 64]  = t_s2[p];
            robid_ex0[p*6 +: 6]   = t_rid[p];
        end
    end

    // Reference model state: EX1 contents and the pending redirect
    logic        m1_vld [NP];
    logic        m1_mp  [NP];
    logic        m1_uc  [NP];
    logic [63:0] m1_nxt [NP];
    logic [63:0] m1_tgt [NP];
    logic [5:0]  m1_rid [NP];
    logic        m_pv;
    logic        m_pu;
    logic [63:0] m_pt;
    logic [5:0]  m_pr;
    int          m_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // a older than b: forward distance from a to b, modulo ROB size, is under half
    function automatic bit is_older(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] d;
        d = a - b;
        return d > 6'd32;
    endfunction

    task automatic ref_ex0(input int p, output logic vld, output logic mp,
                           output logic uc, output logic [63:0] nxt,
                           output logic [63:0] tgt);
        logic        tkn;
        logic [63:0] ttgt;
        uc  = t_ucr[p] && !t_eom[p];
        nxt = uc ? 64'((int'(t_rom[p]) + 1) % 4096) : t_pc[p] + 64'd4;
        case (t_uop[p])
            4'd0:    tkn = (t_s1[p] == t_s2[p]);
            4'd1:    tkn = (t_s1[p] != t_s2[p]);
            4'd2:    tkn = ($signed(t_s1[p]) <  $signed(t_s2[p]));
            4'd3:    tkn = ($signed(t_s1[p]) >= $signed(t_s2[p]));
            4'd4:    tkn = (t_s1[p] <  t_s2[p]);
            4'd5:    tkn = (t_s1[p] >= t_s2[p]);
            4'd6,
            4'd7:    tkn = 1'b1;
            default: tkn = 1'b0;
        endcase
        ttgt = (t_uop[p] == 4'd7) ? ((t_s1[p] + t_imm[p]) & ~64'd1) : (t_pc[p] + t_imm[p]);
        tgt  = tkn ? ttgt : nxt;
        vld  = t_iss[p] && (t_uop[p] < 4'd8);
        mp   = vld && (tgt != nxt);
    endtask

    task automatic step();
        logic        v0 [NP];
        logic        mp0[NP];
        logic        u0 [NP];
        logic [63:0] n0 [NP];
        logic [63:0] g0 [NP];
        logic [NP-1:0] ev;
        int ci;
        for (int p = 0; p < NP; p++) ref_ex0(p, v0[p], mp0[p], u0[p], n0[p], g0[p]);
        @(posedge clk);
        if (!reset) begin
            m_pv = 1'b0; m_pu = 1'b0; m_pt = '0; m_pr = '0; m_cnt = 0;
            for (int p = 0; p < NP; p++) begin
                m1_vld[p] = 1'b0; m1_mp[p] = 1'b0; m1_uc[p] = 1'b0;
                m1_nxt[p] = '0;   m1_tgt[p] = '0;  m1_rid[p] = '0;
            end
        end else begin
            ci = -1;
            for (int p = 0; p < NP; p++)
                if (m1_mp[p] && (ci < 0 || is_older(m1_rid[p], m1_rid[ci]))) ci = p;
            if (ci >= 0 && (!m_pv || is_older(m1_rid[ci], m_pr))) begin
                m_pv = 1'b1; m_pt = m1_tgt[ci]; m_pr = m1_rid[ci]; m_pu = m1_uc[ci];
                if (m_cnt < 65535) m_cnt++;
            end else if (m_pv && flush_ack) begin
                m_pv = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                m1_vld[p] = v0[p]; m1_mp[p] = mp0[p]; m1_uc[p] = u0[p];
                m1_nxt[p] = n0[p]; m1_tgt[p] = g0[p]; m1_rid[p] = t_rid[p];
            end
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            ev[p] = m1_vld[p];
            chk($sformatf("result%0d", p), result_ex1[p*64 +: 64], m1_nxt[p]);
        end
        chk("resvld", 64'(resvld_ex1), 64'(ev));
        chk("mp_valid", 64'(mispred_valid), 64'(m_pv));
        chk("mp_cnt", 64'(mispred_cnt), 64'(m_cnt));
        if (m_pv) begin
            chk("mp_target", mispred_target, m_pt);
            chk("mp_robid", 64'(mispred_robid), 64'(m_pr));
            chk("mp_ucbr", 64'(mispred_ucbr), 64'(m_pu));
        end
    endtask

    task automatic clear_in();
        for (int p = 0; p < NP; p++) begin
            t_iss[p] = 1'b0; t_uop[p] = 4'd15; t_pc[p] = '0; t_imm[p] = '0;
            t_s1[p] = '0; t_s2[p] = '0; t_rom[p] = '0; t_ucr[p] = 1'b0;
            t_eom[p] = 1'b0; t_rid[p] = '0;
        end
    endtask

    task automatic set_port(input int p, input logic [3:0] uop, input logic [63:0] pc,
                            input logic [63:0] imm, input logic [63:0] s1,
                            input logic [63:0] s2, input logic [5:0] rid,
                            input logic ucr, input logic eom, input logic [11:0] rom);
        t_iss[p] = 1'b1; t_uop[p] = uop; t_pc[p] = pc; t_imm[p] = imm;
        t_s1[p] = s1; t_s2[p] = s2; t_rid[p] = rid;
        t_ucr[p] = ucr; t_eom[p] = eom; t_rom[p] = rom;
    endtask

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return 64'd5;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return {$urandom, $urandom};
            default: return 64'd0;
        endcase
    endfunction

    task automatic rand_inputs();
        logic [31:0] r;
        logic [4:0]  lo;
        for (int p = 0; p < NP; p++) begin
            r        = $urandom;
            t_iss[p] = ($urandom_range(0, 3) != 0);
            t_uop[p] = 4'($urandom_range(0, 9));
            t_pc[p]  = {$urandom, $urandom} & ~64'h3;
            t_imm[p] = {{52{r[11]}}, r[11:0]};
            t_s1[p]  = pick_op();
            t_s2[p]  = pick_op();
            t_ucr[p] = ($urandom_range(0, 3) == 0);
            t_eom[p] = 1'($urandom_range(0, 1));
            t_rom[p] = 12'($urandom_range(0, 12'hFFE));
        end
        // Simultaneous ports never share an age, even across the wrap bit
        t_rid[0] = 6'($urandom);
        lo       = t_rid[0][4:0] + 5'($urandom_range(1, 31));
        t_rid[1] = {1'($urandom_range(0, 1)), lo};
    endtask

    initial begin
        reset = 1'b0; flush_ack = 1'b0;
        clear_in();
        step(); step();
        chk("rst_target", mispred_target, 64'h0);
        chk("rst_robid", 64'(mispred_robid), 64'h0);
        chk("rst_valid", 64'(mispred_valid), 64'h0);
        reset = 1'b1;

        // Taken BEQ on port 0
        set_port(0, 4'd0, 64'h1000, 64'h40, 64'd5, 64'd5, 6'h01, 1'b0, 1'b0, 12'h0);
        step(); clear_in();
        chk("tp1_result", result_ex1[63:0], 64'h1004);
        step();
        chk("tp1_target", mispred_target, 64'h1040);
        flush_ack = 1'b1; step(); flush_ack = 1'b0;
        chk("tp1_ack", 64'(mispred_valid), 64'h0);

        // Not-taken BNE on port 1
        set_port(1, 4'd1, 64'h1100, 64'h40, 64'd5, 64'd5, 6'h02, 1'b0, 1'b0, 12'h0);
        step(); clear_in();
        chk("tp2_result", result_ex1[127:64], 64'h1104);
        step();
        chk("tp2_cnt", 64'(mispred_cnt), 64'd1);

        // Dual mispredict across the wrap bit
        reset = 1'b0; step(); reset = 1'b1;
        set_port(0, 4'd6, 64'h1F00, 64'h100, 64'd0, 64'd0, 6'h03, 1'b0, 1'b0, 12'h0);
        set_port(1, 4'd6, 64'h2F00, 64'h100, 64'd0, 64'd0, 6'h21, 1'b0, 1'b0, 12'h0);
        step(); clear_in(); step();
        chk("tp3_robid", 64'(mispred_robid), 64'h03);
        chk("tp3_target", mispred_target, 64'h2000);
        chk("tp3_cnt", 64'(mispred_cnt), 64'd1);
        flush_ack = 1'b1; step(); flush_ack = 1'b0;

        // Older JALR replaces pending, younger one ignored
        reset = 1'b0; step(); reset = 1'b1;
        set_port(0, 4'd6, 64'h0F00, 64'h100, 64'd0, 64'd0, 6'h10, 1'b0, 1'b0, 12'h0);
        step(); clear_in(); step();
        set_port(1, 4'd7, 64'h0100, 64'h0, 64'h5001, 64'd0, 6'h0C, 1'b0, 1'b0, 12'h0);
        step(); clear_in(); step();
        chk("tp4_target", mispred_target, 64'h5000);
        chk("tp4_cnt", 64'(mispred_cnt), 64'd2);
        set_port(0, 4'd6, 64'h0F00, 64'h100, 64'd0, 64'd0, 6'h12, 1'b0, 1'b0, 12'h0);
        step(); clear_in(); step();
        chk("tp4_robid", 64'(mispred_robid), 64'h0C);
        flush_ack = 1'b1; step(); flush_ack = 1'b0;

        // Ucode branch
        set_port(0, 4'd0, 64'h4000, 64'h10, 64'd5, 64'd5, 6'h05, 1'b1, 1'b0, 12'h07F);
        step(); clear_in();
        chk("tp5_result", result_ex1[63:0], 64'h80);
        step();
        chk("tp5_ucbr", 64'(mispred_ucbr), 64'h1);
        flush_ack = 1'b1; step(); flush_ack = 1'b0;
        chk("tp5_ack", 64'(mispred_valid), 64'h0);

        // Reset while pending, then branches under reset
        set_port(0, 4'd6, 64'h0800, 64'h100, 64'd0, 64'd0, 6'h07, 1'b0, 1'b0, 12'h0);
        step(); clear_in(); step();
        reset = 1'b0; step();
        chk("tp6_target", mispred_target, 64'h0);
        chk("tp6_robid", 64'(mispred_robid), 64'h0);
        chk("tp6_ucbr", 64'(mispred_ucbr), 64'h0);
        set_port(0, 4'd6, 64'h0800, 64'h100, 64'd0, 64'd0, 6'h08, 1'b0, 1'b0, 12'h0);
        set_port(1, 4'd0, 64'h0900, 64'h100, 64'd1, 64'd1, 6'h09, 1'b0, 1'b0, 12'h0);
        step(); step();
        chk("tp6_resvld", 64'(resvld_ex1), 64'h0);
        reset = 1'b1; clear_in(); step();

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            flush_ack = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibr_mp.md
Name: ibr_mp

Overview:
- Multi-port integer branch resolution unit; next generation of the single-port EX0 branch unit.
- NUM_PORTS branch pipes resolve in EX0 and register results into EX1.
- EX1 mispredicts arbitrate oldest-first by ROB age. The winner is held in a pending register until the flush controller acknowledges it.
- Sits between the branch issue ports and the ROB/fetch redirect logic.

Parameters:
NUM_PORTS, 2, number of branch execution pipes
XLEN, 64, source operand and result width
PADDR_W, 64, PC/target width
ROM_W, 12, ucode ROM address width
ROBID_W, 6, robid width; MSB is the wrap bit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
iss_ex0  in  NUM_PORTS  per-port issue valid
uop_ex0  in  NUM_PORTS*4  per-port uop: 0 EQ,1 NE,2 LT,3 GE,4 LTU,5 GEU,6 JAL,7 JALR, other = non-branch
pc_ex0  in  NUM_PORTS*PADDR_W  instruction PC
rom_addr_ex0  in  NUM_PORTS*ROM_W  ucode ROM address
from_ucrom_ex0  in  NUM_PORTS  uop sourced from ucode ROM
eom_ex0  in  NUM_PORTS  end-of-macro marker
imm_ex0  in  NUM_PORTS*XLEN  sign-extended immediate
src1_ex0, src2_ex0  in  NUM_PORTS*XLEN  operands
robid_ex0  in  NUM_PORTS*ROBID_W  ROB id
flush_ack  in  1  redirect consumed pending mispredict
resvld_ex1  out  NUM_PORTS  per-port result valid
result_ex1  out  NUM_PORTS*XLEN  link value (next PC / next uPC, zero-extended)
mispred_valid  out  1  pending mispredict present
mispred_target  out  PADDR_W  redirect target
mispred_robid  out  ROBID_W  robid of mispredicting branch
mispred_ucbr  out  1  redirect is a ucode branch
mispred_cnt  out  16  saturating count of captured mispredicts

Behaviour:
- Reset (reset==0 at posedge): resvld_ex1=0, result_ex1=0, mispred_valid=0, target/robid/ucbr=0, mispred_cnt=0, FSM=IDLE.
- EX0, per port:
  - ucbr = from_ucrom & ~eom.
  - nxt = ucbr ? zext(rom_addr+1) : pc+4.
  - Taken target: JALR uses (src1+imm) & ~1; all other branches use pc+imm.
  - Taken: EQ/NE compare equality; LT/GE compare signed; LTU/GEU compare unsigned; JAL/JALR are always taken.
  - true_tgt = tkn ? tkn_tgt : nxt.
  - mp = valid_br & (true_tgt != nxt), where valid_br = iss & uop in 0..7.
- EX1: one-cycle registered stage.
  - resvld_ex1 = valid_br, result_ex1 = nxt.
  - mp, true_tgt, robid and ucbr are carried alongside.
  - Pipeline latency issue->resvld is 1 cycle.
- Age compare, older(a,b):
  - Same wrap bit: low bits a<b.
  - Different wrap bits: low bits a>b.
  - Ties cannot occur across valid ports.
- Arbitration: among EX1 ports with mp, pick the oldest (cand). Equal-age candidates are impossible.
- FSM IDLE:
  - cand exists -> capture cand into pending, mispred_valid=1 next cycle, go to PEND.
- FSM PEND:
  - Outputs held stable.
  - cand older than pending -> replace pending (target/robid/ucbr). Count increments.
  - cand younger or equal -> ignored.
  - flush_ack & no older cand -> IDLE, mispred_valid=0 next cycle.
  - flush_ack & older cand in the same cycle -> capture cand, stay in PEND.
- flush_ack while IDLE: ignored.
- mispred_cnt: +1 per capture or replacement; saturates at 16'hFFFF.
- Reset mid-PEND discards the pending mispredict.

Test Plan:
- Port0: BEQ pc=0x1000, imm=0x40, src1=src2=5 -> cycle+1: resvld_ex1[0]=1, result=0x1004; cycle+2: mispred_valid=1, target=0x1040.
- Port1: BNE src1=src2=5 (not taken) -> resvld_ex1[1]=1, result=pc+4, no mispredict, mispred_cnt unchanged.
- Same cycle, both ports mispredict: robid 0x03 (tgt 0x2000) and robid 0x21 (wrap set, tgt 0x3000) -> 0x03 is older (different wrap, 3 > 1); pending robid=0x03, tgt=0x2000, cnt=1.
- PEND on robid 0x10; JALR robid 0x0C, src1=0x5001, imm=0 arrives -> replaced, target=0x5000, cnt=2. A later robid 0x12 is ignored.
- Ucode branch: from_ucrom=1, eom=0, rom_addr=0x07F, taken target differs -> result_ex1=0x80, mispred_ucbr=1. flush_ack -> mispred_valid=0 next cycle.
- reset=0 while PEND -> all outputs 0 next cycle. With reset held at 0, issued branches produce no resvld.
